// File: rtl/ldst_compact_queue_if.sv
// Load/store compacting queue: bundled handshake, retire mask and entry view.
interface ldst_compact_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   flush;
  logic                   enq_valid;
  logic [WIDTH-1:0]       enq_data;
  logic                   enq_ready;
  logic [DEPTH-1:0]       issue_mask;
  logic [DEPTH*WIDTH-1:0] entry_data;
  logic [DEPTH-1:0]       entry_valid;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;

  // Producer / consumer side (testbench or surrounding pipeline)
  modport master (
    output flush, enq_valid, enq_data, issue_mask,
    input  enq_ready, entry_data, entry_valid, count, full, empty
  );

  // Queue side
  modport slave (
    input  flush, enq_valid, enq_data, issue_mask,
    output enq_ready, entry_data, entry_valid, count, full, empty
  );
endinterface

// File: rtl/ldst_compact_queue.sv
// Age-ordered queue with arbitrary-pattern retirement and same-edge compaction.
// Valid entries always occupy indices 0..count-1, index 0 being oldest.
module ldst_compact_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  ldst_compact_queue_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  logic             r_full;
  logic             r_empty;
  logic             r_ready;

  logic [WIDTH-1:0] w_next [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_rm;
  logic [DEPTH-1:0] w_valid_next;
  logic [CW-1:0]    w_keep;
  logic [CW-1:0]    w_cnt_next;
  logic             w_acc;

  // Next-state: drop retired entries, pack survivors downward, append enqueue
  always_comb begin
    w_next       = r_data;
    w_live       = '0;
    w_keep       = '0;
    w_cnt_next   = r_count;
    w_valid_next = '0;
    w_acc        = bus.enq_valid & r_ready;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_live[i] = (CW'(i) < r_count);
    end
    w_rm = bus.issue_mask & w_live;
    if (bus.flush) begin
      w_cnt_next = '0;
    end else begin
      // Survivor i lands at the number of survivors below it
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_live[i] && !w_rm[i]) begin
          w_next[IW'(w_keep)] = r_data[i];
          w_keep              = w_keep + CW'(1);
        end
      end
      // enq_ready came from the pre-removal count, so w_keep < DEPTH here
      if (w_acc) begin
        w_next[IW'(w_keep)] = bus.enq_data;
      end
      w_cnt_next = w_keep + CW'(w_acc);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_valid_next[i] = (CW'(i) < w_cnt_next);
    end
  end

  // State and registered status flags; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
      end
      r_count <= '0;
      r_valid <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_data  <= w_next;
      r_count <= w_cnt_next;
      r_valid <= w_valid_next;
      r_full  <= (w_cnt_next == CW'(DEPTH));
      r_empty <= (w_cnt_next == '0);
      r_ready <= (w_cnt_next != CW'(DEPTH));
    end
  end

  // Flatten entry payloads onto the output bus
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_out
    assign bus.entry_data[g*WIDTH +: WIDTH] = r_data[g];
  end

  assign bus.entry_valid = r_valid;
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;
  assign bus.enq_ready   = r_ready;
endmodule

// File: tb/tb_ldst_compact_queue.sv
// Scoreboard bench for ldst_compact_queue: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_ldst_compact_queue;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct {
    int                     cnt;
    logic [DEPTH*WIDTH-1:0] data;
  } exp_t;

  logic clk;
  logic reset;

  ldst_compact_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ldst_compact_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  exp_t             sb [$];
  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] mem [DEPTH];

  task automatic chk(input string name, input logic [DEPTH*WIDTH-1:0] act,
                     input logic [DEPTH*WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the reference model, queue the expectation
  task automatic step(input logic rst, input logic fl, input logic ev,
                      input logic [WIDTH-1:0] ed, input logic [DEPTH-1:0] im);
    logic [WIDTH-1:0] nq [$];
    logic             ready;
    exp_t             e;
    reset          = rst;
    bus.flush      = fl;
    bus.enq_valid  = ev;
    bus.enq_data   = ed;
    bus.issue_mask = im;
    ready = (mq.size() < int'(DEPTH));
    if (rst) begin
      mq.delete();
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) if (!im[i]) nq.push_back(mq[i]);
      if (ev && ready) nq.push_back(ed);
      mq = nq;
      for (int i = 0; i < mq.size(); i++) mem[i] = mq[i];
    end
    e.cnt  = mq.size();
    e.data = '0;
    for (int i = 0; i < int'(DEPTH); i++) e.data[i*WIDTH +: WIDTH] = mem[i];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge produces an observable state; compare it to the oldest expectation
  always begin
    exp_t e;
    logic [DEPTH-1:0] vm;
    @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      vm = '0;
      for (int i = 0; i < e.cnt; i++) vm[i] = 1'b1;
      chk("count",       (DEPTH*WIDTH)'(bus.count),       (DEPTH*WIDTH)'(e.cnt));
      chk("entry_valid", (DEPTH*WIDTH)'(bus.entry_valid), (DEPTH*WIDTH)'(vm));
      chk("full",        (DEPTH*WIDTH)'(bus.full),        (DEPTH*WIDTH)'(e.cnt == int'(DEPTH)));
      chk("empty",       (DEPTH*WIDTH)'(bus.empty),       (DEPTH*WIDTH)'(e.cnt == 0));
      chk("enq_ready",   (DEPTH*WIDTH)'(bus.enq_ready),   (DEPTH*WIDTH)'(e.cnt < int'(DEPTH)));
      chk("entry_data",  bus.entry_data,                  e.data);
    end
  end

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic enq(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b0, 1'b1, d, '0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.enq_valid  = 1'b0;
    bus.enq_data   = '0;
    bus.issue_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle();

    // Fill to full, then an extra enqueue that must be dropped
    for (int i = 0; i < 8; i++) enq(WIDTH'(32'hA0 + i));
    enq(32'hEE);

    // Scattered retirement of a full queue
    step(1'b0, 1'b0, 1'b0, '0, 8'b1010_0101);
    idle();

    // Retire oldest while enqueueing
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) enq(WIDTH'(32'hA0 + i));
    step(1'b0, 1'b0, 1'b1, 32'hB0, 8'h01);
    idle();

    // Full queue drained completely with a simultaneous (dropped) enqueue
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) enq(WIDTH'(32'hA0 + i));
    step(1'b0, 1'b0, 1'b1, 32'hC0, 8'hFF);
    idle();

    // Masks on invalid entries, then flush with enqueue
    step(1'b1, 1'b0, 1'b0, '0, '0);
    enq(32'hD0);
    enq(32'hD1);
    step(1'b0, 1'b0, 1'b0, '0, 8'hFC);
    step(1'b0, 1'b1, 1'b1, 32'hD2, 8'hFF);
    idle();
    enq(32'hD3);

    // Reset mid-operation overriding enqueue and retirement
    for (int i = 0; i < 4; i++) enq(WIDTH'(32'hE0 + i));
    step(1'b1, 1'b0, 1'b1, 32'hF0, 8'h01);
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic             r_rst;
      logic             r_fl;
      logic             r_ev;
      logic [DEPTH-1:0] r_im;
      r_rst = ($urandom_range(0, 299) == 0);
      r_fl  = ($urandom_range(0, 79) == 0);
      r_ev  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       r_im = '0;
        1:       r_im = DEPTH'($urandom & $urandom & $urandom);
        2:       r_im = DEPTH'($urandom);
        default: r_im = DEPTH'($urandom & $urandom);
      endcase
      step(r_rst, r_fl, r_ev, WIDTH'($urandom), r_im);
    end

    idle();
    repeat (2) @(posedge clk);
    #5;
    chk("scoreboard_drained", (DEPTH*WIDTH)'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
